// File: rtl/rx_merge_logic.sv
// Drains destination FIFOs D0/D1 with round-robin pops, checks each word's
// destination bit against its source and merges both streams into one buffered valid/ready output.
module rx_merge_logic #(
   parameter int data_width = 6,
   parameter int buf_depth  = 4,
   parameter int cnt_width  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [data_width-1:0] data_in_D0,
   input  logic [data_width-1:0] data_in_D1,
   input  logic                  empty_fifo_D0,
   input  logic                  empty_fifo_D1,
   input  logic                  ready_in,
   output logic                  pop_D0,
   output logic                  pop_D1,
   output logic [data_width-1:0] data_out,
   output logic                  valid_out,
   output logic                  mismatch_error,
   output logic [cnt_width-1:0]  count_D0,
   output logic [cnt_width-1:0]  count_D1,
   output logic                  idle_out
);

   localparam int AW = $clog2(buf_depth);

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DRAIN} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [data_width-1:0] r_mem [buf_depth];
   logic [AW-1:0]         r_wptr;
   logic [AW-1:0]         r_rptr;
   logic [AW:0]           r_occ;
   logic                  r_inflight;
   logic                  r_inflight_src;
   logic                  r_last_grant;
   logic                  r_err;
   logic [cnt_width-1:0]  r_cnt0;
   logic [cnt_width-1:0]  r_cnt1;

   logic [AW+1:0]         w_pending;
   logic                  w_allow;
   logic                  w_pop0;
   logic                  w_pop1;
   logic                  w_any_pop;
   logic                  w_wr;
   logic                  w_rd;
   logic                  w_occ_zero;
   logic [data_width-1:0] w_cap;

   // Counting the in-flight word against capacity keeps the buffer from overflowing under backpressure.
   assign w_pending  = {1'b0, r_occ} + {{(AW+1){1'b0}}, r_inflight};
   assign w_allow    = w_pending < (AW+2)'(buf_depth);
   assign w_occ_zero = (r_occ == '0);
   assign w_wr       = r_inflight;
   assign w_rd       = !w_occ_zero && ready_in;
   assign w_cap      = r_inflight_src ? data_in_D1 : data_in_D0;
   assign w_any_pop  = w_pop0 | w_pop1;

   always_comb begin
      w_pop0 = 1'b0;
      w_pop1 = 1'b0;
      if (!reset && w_allow) begin
         if (!empty_fifo_D0 && !empty_fifo_D1) begin
            if (r_last_grant) w_pop0 = 1'b1;
            else              w_pop1 = 1'b1;
         end else if (!empty_fifo_D0) begin
            w_pop0 = 1'b1;
         end else if (!empty_fifo_D1) begin
            w_pop1 = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr         <= '0;
         r_rptr         <= '0;
         r_occ          <= '0;
         r_inflight     <= 1'b0;
         r_inflight_src <= 1'b0;
         r_last_grant   <= 1'b1;
         r_err          <= 1'b0;
         r_cnt0         <= '0;
         r_cnt1         <= '0;
      end else begin
         r_inflight <= w_any_pop;
         if (w_any_pop) begin
            r_inflight_src <= w_pop1;
            r_last_grant   <= w_pop1;
         end
         if (w_wr) begin
            r_wptr <= r_wptr + 1'b1;
            if (r_inflight_src) r_cnt1 <= r_cnt1 + 1'b1;
            else                r_cnt0 <= r_cnt0 + 1'b1;
            if (w_cap[4] != r_inflight_src) r_err <= 1'b1;
         end
         if (w_rd) r_rptr <= r_rptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Storage needs no reset: data_out is masked to zero while the buffer is empty.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= w_cap;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_any_pop) w_state_next = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (empty_fifo_D0 && empty_fifo_D1 && !r_inflight)
               w_state_next = w_occ_zero ? ST_IDLE : ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_any_pop)                     w_state_next = ST_ACTIVE;
            else if (w_occ_zero && !r_inflight) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   assign pop_D0         = w_pop0;
   assign pop_D1         = w_pop1;
   assign valid_out      = !w_occ_zero;
   assign data_out       = w_occ_zero ? '0 : r_mem[r_rptr];
   assign mismatch_error = r_err;
   assign count_D0       = r_cnt0;
   assign count_D1       = r_cnt1;
   assign idle_out       = (r_state == ST_IDLE);

endmodule

// File: tb/tb_rx_merge_logic.sv
// Bench for rx_merge_logic: FIFO environment, queue-based reference model checked every cycle,
// and literal expectations for the directed scenarios.
module tb_rx_merge_logic;

   localparam int DW    = 6;
   localparam int DEPTH = 4;
   localparam int CW    = 8;

   logic          clk;
   logic          reset;
   logic [DW-1:0] data_in_D0;
   logic [DW-1:0] data_in_D1;
   logic          empty_fifo_D0;
   logic          empty_fifo_D1;
   logic          ready_in;
   logic          pop_D0;
   logic          pop_D1;
   logic [DW-1:0] data_out;
   logic          valid_out;
   logic          mismatch_error;
   logic [CW-1:0] count_D0;
   logic [CW-1:0] count_D1;
   logic          idle_out;

   rx_merge_logic #(.data_width(DW), .buf_depth(DEPTH), .cnt_width(CW)) dut (
      .clk(clk), .reset(reset),
      .data_in_D0(data_in_D0), .data_in_D1(data_in_D1),
      .empty_fifo_D0(empty_fifo_D0), .empty_fifo_D1(empty_fifo_D1),
      .ready_in(ready_in), .pop_D0(pop_D0), .pop_D1(pop_D1),
      .data_out(data_out), .valid_out(valid_out), .mismatch_error(mismatch_error),
      .count_D0(count_D0), .count_D1(count_D1), .idle_out(idle_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_bad = 0;

   // FIFO environment contents
   logic [DW-1:0] f0[$];
   logic [DW-1:0] f1[$];
   bit            s_p0, s_p1;
   int            pop_seen;

   // reference model: words stored in the output buffer, one optional word in flight
   logic [DW-1:0] mq[$];
   bit            m_inf, m_src, m_last, m_err;
   logic [CW-1:0] m_c0, m_c1;
   int            quiet;

   logic [DW-1:0] dut_log[$];
   logic [DW-1:0] exp_q[$];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check();
      bit allow, e_p0, e_p1, rd;
      logic [DW-1:0] w;
      if (reset) begin
         chk("rst_pop_D0", int'(pop_D0), 0);
         chk("rst_pop_D1", int'(pop_D1), 0);
         chk("rst_valid", int'(valid_out), 0);
         chk("rst_data", int'(data_out), 0);
         chk("rst_mismatch", int'(mismatch_error), 0);
         chk("rst_count_D0", int'(count_D0), 0);
         chk("rst_count_D1", int'(count_D1), 0);
         chk("rst_idle", int'(idle_out), 1);
         mq.delete();
         m_inf = 0; m_src = 0; m_last = 1; m_err = 0;
         m_c0 = '0; m_c1 = '0; quiet = 0;
         return;
      end
      allow = (mq.size() + int'(m_inf)) < DEPTH;
      e_p0 = 0; e_p1 = 0;
      if (allow) begin
         if (!empty_fifo_D0 && !empty_fifo_D1) begin
            if (m_last) e_p0 = 1; else e_p1 = 1;
         end else if (!empty_fifo_D0) e_p0 = 1;
         else if (!empty_fifo_D1) e_p1 = 1;
      end
      chk("pop_D0", int'(pop_D0), int'(e_p0));
      chk("pop_D1", int'(pop_D1), int'(e_p1));
      chk("valid_out", int'(valid_out), int'(mq.size() > 0));
      if (mq.size() > 0) chk("data_out", int'(data_out), int'(mq[0]));
      chk("count_D0", int'(count_D0), int'(m_c0));
      chk("count_D1", int'(count_D1), int'(m_c1));
      chk("mismatch_error", int'(mismatch_error), int'(m_err));
      if (!m_inf && mq.size() == 0 && !e_p0 && !e_p1) quiet++;
      else quiet = 0;
      if (mq.size() > 0) chk("idle_busy", int'(idle_out), 0);
      else if (quiet >= 3) chk("idle_quiet", int'(idle_out), 1);
      if (valid_out && ready_in) dut_log.push_back(data_out);
      rd = (mq.size() > 0) && ready_in;
      if (rd) void'(mq.pop_front());
      if (m_inf) begin
         w = m_src ? data_in_D1 : data_in_D0;
         mq.push_back(w);
         if (m_src) m_c1 = m_c1 + 8'd1; else m_c0 = m_c0 + 8'd1;
         if (w[4] != m_src) m_err = 1;
      end
      m_inf = e_p0 | e_p1;
      if (m_inf) begin
         m_src  = e_p1;
         m_last = e_p1;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check();
      s_p0 = pop_D0;
      s_p1 = pop_D1;
      if (pop_D0 || pop_D1) pop_seen++;
      @(posedge clk);
      #1;
      if (s_p0 && f0.size() > 0) data_in_D0 = f0.pop_front();
      if (s_p1 && f1.size() > 0) data_in_D1 = f1.pop_front();
      empty_fifo_D0 = (f0.size() == 0);
      empty_fifo_D1 = (f1.size() == 0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push0(input logic [DW-1:0] v);
      f0.push_back(v);
      empty_fifo_D0 = 1'b0;
   endtask

   task automatic push1(input logic [DW-1:0] v);
      f1.push_back(v);
      empty_fifo_D1 = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ticks(2);
      reset = 1'b0;
      dut_log.delete();
   endtask

   task automatic cmp_log(input string name);
      chk({name, "_len"}, dut_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < dut_log.size())
            chk($sformatf("%s[%0d]", name, i), int'(dut_log[i]), int'(exp_q[i]));
   endtask

   initial begin
      reset = 1'b1; ready_in = 1'b1;
      empty_fifo_D0 = 1'b1; empty_fifo_D1 = 1'b1;
      data_in_D0 = '0; data_in_D1 = '0;
      pop_seen = 0;

      // reset and quiet operation
      ticks(3);
      reset = 1'b0;
      pop_seen = 0;
      ticks(10);
      chk("quiet_pops", pop_seen, 0);
      chk("quiet_idle", int'(idle_out), 1);

      // two words from D0 only
      dut_log.delete();
      push0(6'h05); push0(6'h0A);
      ticks(10);
      exp_q = '{6'h05, 6'h0A};
      cmp_log("d0_only");
      chk("d0_only_count", int'(count_D0), 2);
      chk("d0_only_err", int'(mismatch_error), 0);
      chk("d0_only_idle", int'(idle_out), 1);

      // interleaved round-robin
      do_reset();
      push0(6'h01); push0(6'h02); push0(6'h03);
      push1(6'h11); push1(6'h12); push1(6'h13);
      ticks(16);
      exp_q = '{6'h01, 6'h11, 6'h02, 6'h12, 6'h03, 6'h13};
      cmp_log("rr");
      chk("rr_count_D0", int'(count_D0), 3);
      chk("rr_count_D1", int'(count_D1), 3);

      // backpressure: buffer fills to depth, then drains in order
      do_reset();
      ready_in = 1'b0;
      pop_seen = 0;
      for (int i = 1; i <= 8; i++) push0(6'(32 + i));
      ticks(12);
      chk("bp_pops", pop_seen, 4);
      chk("bp_valid", int'(valid_out), 1);
      chk("bp_head", int'(data_out), 6'h21);
      ready_in = 1'b1;
      ticks(15);
      exp_q = '{6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h28};
      cmp_log("bp");

      // destination mismatch from D1
      do_reset();
      push1(6'h07); push1(6'h12); push1(6'h15);
      ticks(10);
      exp_q = '{6'h07, 6'h12, 6'h15};
      cmp_log("mm");
      chk("mm_flag", int'(mismatch_error), 1);
      chk("mm_count_D1", int'(count_D1), 3);
      ticks(3);
      chk("mm_sticky", int'(mismatch_error), 1);

      // reset with two words buffered and one in flight
      do_reset();
      ready_in = 1'b0;
      push0(6'h0A); push0(6'h0B); push0(6'h0C);
      ticks(3);
      chk("pre_rst_valid", int'(valid_out), 1);
      chk("pre_rst_head", int'(data_out), 6'h0A);
      reset = 1'b1;
      #1;
      chk("rst_valid_now", int'(valid_out), 0);
      tick();
      reset = 1'b0;
      ready_in = 1'b1;
      dut_log.delete();
      ticks(8);
      chk("mid_rst_log_len", dut_log.size(), 0);
      chk("mid_rst_count", int'(count_D0), 0);

      // counter wrap: 300 words mod 256
      do_reset();
      for (int i = 0; i < 300; i++) push0(6'(i % 16));
      ticks(330);
      chk("wrap_count_D0", int'(count_D0), 44);
      chk("wrap_log_len", dut_log.size(), 300);
      chk("wrap_err", int'(mismatch_error), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
